// File: rtl/nor_latch_bank_if.sv
// Signal bundle for nor_latch_bank: set/clear drive in, latch state and flags out.
interface nor_latch_bank_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] set;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] conflict;
  logic [WIDTH-1:0] race;
  logic [WIDTH-1:0] changed;

  // Driver side (control-pulse decoder).
  modport master (
    output en, set, clr,
    input  q, qn, conflict, race, changed
  );

  // Latch bank side.
  modport slave (
    input  en, set, clr,
    output q, qn, conflict, race, changed
  );
endinterface

// File: rtl/nor_latch_bank.sv
// Bank of WIDTH independent cross-coupled NOR set/reset latches with a DELAY-cycle
// output pipeline modelling gate propagation. Stage 0 of the pipeline is the latch core.
module nor_latch_bank #(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      DELAY = 1,   // legal range 1..8
  parameter logic [WIDTH-1:0] IV    = '0
) (
  input logic             clk_i,
  input logic             rst_ni,
  nor_latch_bank_if.slave bus
);

  // Pipeline stages; index 0 holds the core latch state, index DELAY-1 drives the outputs.
  logic [WIDTH-1:0] q_q  [DELAY];
  logic [WIDTH-1:0] qn_q [DELAY];
  logic [WIDTH-1:0] cf_q [DELAY];
  logic [WIDTH-1:0] rc_q [DELAY];
  logic [WIDTH-1:0] q_prev_q;

  logic [WIDTH-1:0] sq_d;
  logic [WIDTH-1:0] sqn_d;
  logic [WIDTH-1:0] rc_d;
  logic [WIDTH-1:0] both_low;
  logic [WIDTH-1:0] release_in;

  // Core next-state: NOR-latch truth table, with both-low release resolving to IV.
  always_comb begin
    both_low   = ~q_q[0] & ~qn_q[0];
    release_in = ~bus.set & ~bus.clr;
    sq_d       = q_q[0];
    sqn_d      = qn_q[0];
    rc_d       = '0;
    if (bus.en) begin
      sq_d  = (bus.set & ~bus.clr)
            | (release_in & ((both_low & IV) | (~both_low & q_q[0])));
      sqn_d = (bus.clr & ~bus.set)
            | (release_in & ((both_low & ~IV) | (~both_low & qn_q[0])));
      rc_d  = release_in & both_low;
    end
  end

  // Core registers plus delay pipeline; reset flushes every stage to the power-on value.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < DELAY; k++) begin
        q_q[k]  <= IV;
        qn_q[k] <= ~IV;
        cf_q[k] <= '0;
        rc_q[k] <= '0;
      end
    end else begin
      q_q[0]  <= sq_d;
      qn_q[0] <= sqn_d;
      cf_q[0] <= ~sq_d & ~sqn_d;
      rc_q[0] <= rc_d;
      for (int k = 1; k < DELAY; k++) begin
        q_q[k]  <= q_q[k-1];
        qn_q[k] <= qn_q[k-1];
        cf_q[k] <= cf_q[k-1];
        rc_q[k] <= rc_q[k-1];
      end
    end
  end

  // Previous output value for edge detection on q.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_prev_q <= IV;
    end else begin
      q_prev_q <= q_q[DELAY-1];
    end
  end

  assign bus.q        = q_q[DELAY-1];
  assign bus.qn       = qn_q[DELAY-1];
  assign bus.conflict = cf_q[DELAY-1];
  assign bus.race     = rc_q[DELAY-1];
  assign bus.changed  = q_q[DELAY-1] ^ q_prev_q;

endmodule
